oled_spi_sink: RTL and testbench
================================

# oled_spi_sink

Receive-side counterpart of the OLED SPI controller: an SPI mode-0 peripheral that oversamples `spi_clk`/`spi_mosi`/`spi_ncs` in the system clock domain and assembles MSB-first bytes. It tags the first byte of each chip-select window as a command byte and delivers bytes through a small FIFO with a valid/ready handshake. It serves as an on-FPGA loopback sink and display stand-in for checking the OLED controller's init and refresh traffic without a panel attached.

## Interface
- `FIFO_DEPTH`, default 4: output FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, default 2: synchronizer flops on each SPI input; at least 2.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `spi_clk` in 1: SPI clock from the controller; asynchronous to `clk`.
- `spi_mosi` in 1: SPI data.
- `spi_ncs` in 1: chip select, active low.
- `lcd_nrst` in 1: panel reset, active low. While low, acts as a synchronous clear of the shifter, FIFO and error flags.
- `out_data` out 8: received byte.
- `out_first` out 1: byte was the first in its CS window (command byte).
- `out_valid` out 1: a FIFO head entry is available.
- `out_ready` in 1: consumer accepts the byte.
- `byte_count` out 16: total bytes completed since reset; wraps at 65535 to 0.
- `active` out 1: synchronized CS is asserted.
- `frame_err` out 1: sticky flag; CS deasserted mid-byte.
- `overflow` out 1: sticky flag; a byte completed while the FIFO was full.
- `clr_err` in 1: one-cycle pulse that clears `frame_err` and `overflow`.

## Operation
- Reset values: `out_data`=0, `out_first`=0, `out_valid`=0, `byte_count`=0, `active`=0, `frame_err`=0, `overflow`=0. Reset also clears the shifter, bit counter and FIFO.
- Each SPI input passes through `SYNC_STAGES` flops. `spi_ncs` synchronizes to 1 at reset; the other inputs synchronize to 0.
- Edge detect uses one extra flop on the synchronized `spi_clk`. A rising edge samples the synchronized `spi_mosi`. Falling edges are ignored.
- FSM states:
  - IDLE: synchronized ncs is high.
  - SHIFT: synchronized ncs is low.
- IDLE to SHIFT on synchronized ncs low. On entry: bit_cnt=0, first_pending=1.
- In SHIFT, each sampled bit shifts in: shreg = {shreg[6:0], mosi}, bit_cnt++.
- When bit_cnt reaches 8:
  - push {first_pending, byte} to the FIFO;
  - `byte_count`++ ;
  - bit_cnt=0, first_pending=0.
- SHIFT to IDLE on synchronized ncs high. If bit_cnt is not 0, set `frame_err` and discard the partial byte.
- An `spi_clk` rising edge in IDLE is ignored.
- FIFO push with pop in the same cycle is always accepted, even when full.
- Push when full with no pop: the byte is dropped, `overflow` is set, and `byte_count` still increments.
- `out_data`/`out_first` show the FIFO head while `out_valid`=1. When empty they hold their last value.
- Pop occurs on `out_valid && out_ready`.
- `clr_err` in the same cycle as a new error event: the error wins and the flag stays set.
- `lcd_nrst` low:
  - FSM goes to IDLE, FIFO is emptied, flags are cleared;
  - `byte_count` is kept;
  - SPI edges are ignored until `lcd_nrst` goes high.

## Timing
- Input constraints:
  - `spi_clk` high and low phases are each at least `SYNC_STAGES`+2 `clk` periods.
  - MOSI is stable at least 1 `clk` before and after the rising SCLK edge.
  - CS setup to the first SCLK edge is at least `SYNC_STAGES`+2 `clk` periods.
- Latency: from the 8th `spi_clk` rising edge at the pin to `out_valid` high is `SYNC_STAGES`+2 `clk` cycles, when the FIFO was empty. `byte_count` updates in the same cycle as `out_valid`.
- FIFO has no bypass. `out_valid` is registered.
- Throughput: one byte per `clk` via pop. Worst case SPI input is 1 byte per 8*(2*`SYNC_STAGES`+4) clk.
- `active` lags pin ncs by `SYNC_STAGES`+1 cycles.
- A rst assertion mid-byte clears asynchronously. No error is flagged.

## Structure
- Package `oled_spi_pkg`:
  - `OLED_BYTE_W`=8;
  - typedef `oled_spi_entry_t` as a packed struct {logic first; logic [7:0] data};
  - FSM enum `oled_spi_state_e` {IDLE, SHIFT}.
- Sub-module `oled_spi_fifo`:
  - parameterized synchronous FIFO of `oled_spi_entry_t`;
  - ports push/pop/full/empty/flush;
  - async active-high rst.
- Synchronizers and edge detect are inline in `oled_spi_sink`.

## Test plan
- CS low, send 0xAE, CS high, SCLK = clk/20 → one entry {first=1, data=0xAE}, `byte_count`=1, no errors.
- One CS window carrying 0x81, 0x7F, 0xA5 → three entries with first = 1, 0, 0 and data 0x81, 0x7F, 0xA5 in order; `byte_count`=3.
- Send 5 bytes with `out_ready`=0 and `FIFO_DEPTH`=4 → first 4 kept, `overflow`=1, `byte_count`=5. Then `clr_err` clears `overflow`.
- CS high after 3 bits → `frame_err`=1, no FIFO entry. Next CS window with 0x3C → {first=1, data=0x3C}.
- `lcd_nrst` low for 10 cycles with 2 bytes queued → `out_valid`=0, flags 0, `byte_count` unchanged. Bytes after release are accepted.
- `rst` pulsed mid-byte → all outputs at reset values immediately. The next full byte is received correctly.

Source files
------------

// File: rtl/oled_spi_sink_pkg.sv
// Shared types for the OLED SPI receive sink.
//   OLED_BYTE_W      : width of one SPI byte
//   oled_spi_entry_t : one FIFO entry, the received byte plus its command tag
//   oled_spi_state_e : receive FSM states
package oled_spi_pkg;

    localparam int OLED_BYTE_W = 8;

    typedef struct packed {
        logic                   first;
        logic [OLED_BYTE_W-1:0] data;
    } oled_spi_entry_t;

    typedef enum logic {
        IDLE,
        SHIFT
    } oled_spi_state_e;

endpackage

// File: rtl/oled_spi_sink_if.sv
// Byte stream handshake between the OLED SPI sink and its consumer.
//   out_data  : received byte
//   out_first : byte was the first in its chip-select window (command byte)
//   out_valid : a byte is presented
//   out_ready : consumer accepts the presented byte
// The sink uses the master modport and the consumer uses the slave modport.
interface oled_spi_sink_if;
    import oled_spi_pkg::*;

    logic [OLED_BYTE_W-1:0] out_data;
    logic                   out_first;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output out_data,
        output out_first,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_first,
        input  out_valid,
        output out_ready
    );

endinterface

// File: rtl/oled_spi_sink_fifo.sv
// Small synchronous FIFO of received SPI entries.
//   clk, rst  : system clock, asynchronous active-high reset
//   flush     : synchronous clear of all entries
//   push      : write push_data; accepted when not full or when popping in the same cycle
//   pop       : remove the head entry; ignored when empty
//   pop_data  : head entry, or the last popped entry while empty
//   full      : all entries in use
//   empty     : no entry stored
module oled_spi_fifo
    import oled_spi_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            push,
    input  oled_spi_entry_t push_data,
    input  logic            pop,
    output oled_spi_entry_t pop_data,
    output logic            full,
    output logic            empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    oled_spi_entry_t mem [DEPTH];
    oled_spi_entry_t last_q;
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // When empty the output holds the last entry handed to the consumer.
    assign pop_data = empty ? last_q : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            last_q <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                last_q <= mem[rd_ptr[AW-1:0]];
            end
        end
    end

    // Storage needs no reset; nothing reads a slot before it is written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/oled_spi_sink.sv
// SPI mode-0 receive sink standing in for an OLED panel. Oversamples the SPI
// pins in the clk domain, assembles MSB-first bytes, tags the first byte of
// each chip-select window as a command and queues bytes in a small FIFO.
//   clk, rst   : system clock, asynchronous active-high reset
//   spi_clk    : SPI clock, asynchronous to clk
//   spi_mosi   : SPI data
//   spi_ncs    : chip select, active low
//   lcd_nrst   : panel reset, active low; clears shifter, FIFO and flags
//   out_if     : byte stream (data, first, valid, ready)
//   byte_count : bytes completed since reset, wrapping
//   active     : synchronized chip select is asserted
//   frame_err  : sticky, chip select released mid-byte
//   overflow   : sticky, byte completed while the FIFO was full
//   clr_err    : pulse clearing both sticky flags
module oled_spi_sink
    import oled_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   spi_clk,
    input  logic                   spi_mosi,
    input  logic                   spi_ncs,
    input  logic                   lcd_nrst,
    oled_spi_sink_if.master        out_if,
    output logic [15:0]            byte_count,
    output logic                   active,
    output logic                   frame_err,
    output logic                   overflow,
    input  logic                   clr_err
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ncs_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s;
    logic                   mosi_s;
    logic                   ncs_s;
    logic                   sclk_rise;

    oled_spi_state_e        state_q;
    oled_spi_state_e        state_d;

    logic [OLED_BYTE_W-1:0] shreg_q;
    logic [3:0]             bit_cnt_q;
    logic                   first_pending_q;
    logic                   byte_done;
    logic                   frame_event;
    logic                   overflow_event;

    oled_spi_entry_t        push_entry;
    oled_spi_entry_t        head_entry;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;

    // Synchronizer chains plus one extra flop on spi_clk for edge detection.
    // Chip select idles high so its chain resets to ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], spi_ncs};
            sclk_prev_q <= sclk_s;
        end
    end

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s && !sclk_prev_q;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a held panel reset parks the receiver in IDLE.
    always_comb begin
        state_d = state_q;
        if (!lcd_nrst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (!ncs_s) state_d = SHIFT;
                SHIFT:   if (ncs_s)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // FSM outputs.
    always_comb begin
        active = (state_q == SHIFT);
    end

    // A full byte sits in the shifter for one cycle (bit_cnt == 8) before it
    // is pushed, which gives the fixed SYNC_STAGES+2 pin-to-valid latency.
    assign byte_done      = lcd_nrst && (state_q == SHIFT) && (bit_cnt_q == 4'd8);
    assign frame_event    = lcd_nrst && (state_q == SHIFT) && ncs_s &&
                            (bit_cnt_q != 4'd0) && (bit_cnt_q != 4'd8);
    assign fifo_pop       = !fifo_empty && out_if.out_ready;
    assign overflow_event = byte_done && fifo_full && !fifo_pop;
    assign push_entry     = {first_pending_q, shreg_q};

    // Shifter and bit counter; IDLE re-arms the command tag for the next window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            first_pending_q <= 1'b0;
        end else if (!lcd_nrst) begin
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            first_pending_q <= 1'b0;
        end else if (state_q == IDLE) begin
            bit_cnt_q       <= '0;
            first_pending_q <= 1'b1;
        end else begin
            if (sclk_rise) begin
                shreg_q   <= {shreg_q[OLED_BYTE_W-2:0], mosi_s};
                bit_cnt_q <= byte_done ? 4'd1 : bit_cnt_q + 4'd1;
            end else if (byte_done) begin
                bit_cnt_q <= '0;
            end
            if (byte_done) begin
                first_pending_q <= 1'b0;
            end
        end
    end

    // Byte counter survives panel reset and counts bytes dropped on overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_count <= '0;
        end else if (byte_done) begin
            byte_count <= byte_count + 16'd1;
        end
    end

    // Sticky error flags; a new error outranks a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else if (!lcd_nrst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (frame_event) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (overflow_event) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
        end
    end

    oled_spi_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (!lcd_nrst),
        .push      (byte_done),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head_entry),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.out_data  = head_entry.data;
    assign out_if.out_first = head_entry.first;
    assign out_if.out_valid = !fifo_empty;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Testbench for oled_spi_sink: drives SPI windows at clk/20, queues the
// expected entries and lets a monitor compare every accepted byte.
module tb_oled_spi_sink;
    import oled_spi_pkg::*;

    localparam int SYNC = 2;
    localparam int HALF = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_clk;
    logic        spi_mosi;
    logic        spi_ncs;
    logic        lcd_nrst;
    logic        clr_err;
    logic [15:0] byte_count;
    logic        active;
    logic        frame_err;
    logic        overflow;

    int checks   = 0;
    int failures = 0;

    oled_spi_entry_t exp_q[$];
    oled_spi_entry_t mon_exp;

    oled_spi_sink_if out_if();

    always #5 clk = ~clk;

    oled_spi_sink #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .spi_clk    (spi_clk),
        .spi_mosi   (spi_mosi),
        .spi_ncs    (spi_ncs),
        .lcd_nrst   (lcd_nrst),
        .out_if     (out_if),
        .byte_count (byte_count),
        .active     (active),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clr_err    (clr_err)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expect_entry(input logic first, input logic [7:0] data);
        oled_spi_entry_t e;
        e.first = first;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    // Mode 0: data changes while spi_clk is low and is sampled on the rise.
    task automatic send_bit(input logic b);
        spi_mosi = b;
        tick(HALF);
        spi_clk = 1'b1;
        tick(HALF);
        spi_clk = 1'b0;
    endtask

    // Optionally measures pin-to-valid latency of the last bit (FIFO empty, ready low).
    task automatic send_byte(input logic [7:0] value, input bit check_latency);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = value[i];
            tick(HALF);
            spi_clk = 1'b1;
            if (check_latency && i == 0) begin
                tick(SYNC + 1);
                check_output("latency_not_yet", 32'(out_if.out_valid), 32'd0);
                tick(1);
                check_output("latency_valid", 32'(out_if.out_valid), 32'd1);
                tick(HALF - SYNC - 2);
            end else begin
                tick(HALF);
            end
            spi_clk = 1'b0;
        end
    endtask

    task automatic cs_low();
        spi_ncs = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_high();
        tick(HALF);
        spi_ncs = 1'b1;
        tick(HALF);
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        tick(1);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL %s: %0d entries still outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && out_if.out_valid && out_if.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_entry: got first=%0b data=0x%02h, expected none",
                         out_if.out_first, out_if.out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check_output("entry_first", 32'(out_if.out_first), 32'(mon_exp.first));
                check_output("entry_data", 32'(out_if.out_data), 32'(mon_exp.data));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        spi_clk          = 1'b0;
        spi_mosi         = 1'b0;
        spi_ncs          = 1'b1;
        lcd_nrst         = 1'b1;
        clr_err          = 1'b0;
        out_if.out_ready = 1'b0;
        tick(3);
        check_output("rst_valid", 32'(out_if.out_valid), 32'd0);
        check_output("rst_data", 32'(out_if.out_data), 32'd0);
        check_output("rst_first", 32'(out_if.out_first), 32'd0);
        check_output("rst_count", 32'(byte_count), 32'd0);
        check_output("rst_active", 32'(active), 32'd0);
        check_output("rst_frame_err", 32'(frame_err), 32'd0);
        check_output("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick(5);

        $display("[TB] single command byte 0xAE");
        expect_entry(1'b1, 8'hAE);
        cs_low();
        check_output("active_in_window", 32'(active), 32'd1);
        send_byte(8'hAE, 1'b1);
        cs_high();
        check_output("count_after_ae", 32'(byte_count), 32'd1);
        out_if.out_ready = 1'b1;
        wait_drain("drain_ae");
        check_output("active_after_window", 32'(active), 32'd0);
        check_output("frame_err_after_ae", 32'(frame_err), 32'd0);
        check_output("overflow_after_ae", 32'(overflow), 32'd0);

        $display("[TB] three bytes in one window");
        expect_entry(1'b1, 8'h81);
        expect_entry(1'b0, 8'h7F);
        expect_entry(1'b0, 8'hA5);
        cs_low();
        send_byte(8'h81, 1'b0);
        send_byte(8'h7F, 1'b0);
        send_byte(8'hA5, 1'b0);
        cs_high();
        wait_drain("drain_three");
        check_output("count_after_three", 32'(byte_count), 32'd4);

        $display("[TB] overflow with consumer stalled");
        out_if.out_ready = 1'b0;
        expect_entry(1'b1, 8'h11);
        expect_entry(1'b0, 8'h22);
        expect_entry(1'b0, 8'h33);
        expect_entry(1'b0, 8'h44);
        cs_low();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        cs_high();
        check_output("overflow_set", 32'(overflow), 32'd1);
        check_output("count_after_overflow", 32'(byte_count), 32'd9);
        out_if.out_ready = 1'b1;
        wait_drain("drain_overflow");
        tick(2);
        check_output("empty_after_drain", 32'(out_if.out_valid), 32'd0);
        check_output("hold_last_data", 32'(out_if.out_data), 32'h44);
        check_output("overflow_sticky", 32'(overflow), 32'd1);
        pulse_clr();
        check_output("overflow_cleared", 32'(overflow), 32'd0);

        $display("[TB] chip select released after 3 bits");
        cs_low();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        cs_high();
        check_output("frame_err_set", 32'(frame_err), 32'd1);
        check_output("no_partial_entry", 32'(out_if.out_valid), 32'd0);
        check_output("count_after_partial", 32'(byte_count), 32'd9);
        expect_entry(1'b1, 8'h3C);
        cs_low();
        send_byte(8'h3C, 1'b0);
        cs_high();
        wait_drain("drain_3c");
        check_output("count_after_3c", 32'(byte_count), 32'd10);
        check_output("frame_err_sticky", 32'(frame_err), 32'd1);
        pulse_clr();
        check_output("frame_err_cleared", 32'(frame_err), 32'd0);

        $display("[TB] panel reset with bytes queued");
        out_if.out_ready = 1'b0;
        cs_low();
        send_byte(8'h5A, 1'b0);
        send_byte(8'hC3, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        cs_high();
        check_output("queued_before_nrst", 32'(out_if.out_valid), 32'd1);
        check_output("frame_err_before_nrst", 32'(frame_err), 32'd1);
        lcd_nrst = 1'b0;
        tick(10);
        check_output("nrst_valid", 32'(out_if.out_valid), 32'd0);
        check_output("nrst_frame_err", 32'(frame_err), 32'd0);
        check_output("nrst_overflow", 32'(overflow), 32'd0);
        check_output("nrst_count_kept", 32'(byte_count), 32'd12);
        lcd_nrst = 1'b1;
        tick(2);
        out_if.out_ready = 1'b1;
        expect_entry(1'b1, 8'h96);
        cs_low();
        send_byte(8'h96, 1'b0);
        cs_high();
        wait_drain("drain_96");
        check_output("count_after_nrst", 32'(byte_count), 32'd13);

        $display("[TB] system reset mid-byte");
        out_if.out_ready = 1'b0;
        cs_low();
        send_byte(8'hE7, 1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        #1;
        check_output("midrst_valid", 32'(out_if.out_valid), 32'd0);
        check_output("midrst_data", 32'(out_if.out_data), 32'd0);
        check_output("midrst_count", 32'(byte_count), 32'd0);
        check_output("midrst_active", 32'(active), 32'd0);
        check_output("midrst_frame_err", 32'(frame_err), 32'd0);
        tick(3);
        spi_ncs = 1'b1;
        rst = 1'b0;
        tick(5);
        out_if.out_ready = 1'b1;
        expect_entry(1'b1, 8'h42);
        cs_low();
        send_byte(8'h42, 1'b0);
        cs_high();
        wait_drain("drain_42");
        check_output("count_after_rst", 32'(byte_count), 32'd1);
        check_output("frame_err_after_rst", 32'(frame_err), 32'd0);

        tick(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
